sfifo_ft_param: RTL and testbench

Parametrised synchronous first-word-fall-through FIFO. It is the general successor to the fixed 16-bit × 32-entry FWFT FIFO used in the packet datapath. It adds configurable width and depth, a full-range occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. It is instantiated wherever the queue/buffer managers need small on-chip FIFOs (descriptor queues, pointer free-lists, per-port metadata).

---
 rtl/sfifo_pkg.sv | 11 +
 rtl/sfifo_ptr.sv | 15 +
 rtl/sfifo_ft_param.sv | 65 ++++++
 tb/tb_sfifo_ft_param.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/sfifo_pkg.sv
// sfifo_pkg: shared defaults, count-width helper and configuration check for the FWFT FIFO family
package sfifo_pkg;
  localparam int SFIFO_DEF_W = 16;
  localparam int SFIFO_DEF_D = 32;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic bit cfg_ok(input int depth, input int af, input int ae);
    return depth >= 2 && (depth & (depth - 1)) == 0 && af >= 1 && af <= depth && ae >= 0 && ae <= depth - 1;
  endfunction
endpackage

// File: rtl/sfifo_ptr.sv
// sfifo_ptr: wrapping pointer with increment enable and synchronous clear
module sfifo_ptr #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + 1'b1;
endmodule

// File: rtl/sfifo_ft_param.sv
// sfifo_ft_param: parametrised first-word-fall-through FIFO with level flags, flush and sticky errors
module sfifo_ft_param
  import sfifo_pkg::*;
#(
  parameter int WIDTH = SFIFO_DEF_W,
  parameter int DEPTH = SFIFO_DEF_D,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             err_clr,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    data_count,
  output logic             overflow,
  output logic             underflow
);
  localparam int AW = CW - 1;
  localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C = CW'(AE_LEVEL);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic wr_ok, rd_ok;
  generate
    if (!cfg_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_cfg
      $error("sfifo_ft_param: DEPTH must be a power of two >= 2 and AF/AE levels in range");
    end
  endgenerate
  // a pop frees the slot a simultaneous write into a full FIFO needs
  assign wr_ok = !flush && wr_en && (!full || rd_en);
  assign rd_ok = !flush && rd_en && !empty;
  sfifo_ptr #(.AW(AW)) u_wp (.clk(clk), .rst_n(rst_n), .clr(flush), .inc(wr_ok), .ptr(wp));
  sfifo_ptr #(.AW(AW)) u_rp (.clk(clk), .rst_n(rst_n), .clr(flush), .inc(rd_ok), .ptr(rp));
  always_ff @(posedge clk)
    if (wr_ok) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= flush ? '0 : cnt + CW'(wr_ok) - CW'(rd_ok);
  // set beats err_clr when both land on the same edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (!flush && wr_en && full && !rd_en) || (overflow && !err_clr);
      underflow <= (!flush && rd_en && empty) || (underflow && !err_clr);
    end
  assign dout         = mem[rp];
  assign full         = cnt == FULL_C;
  assign empty        = cnt == '0;
  assign almost_full  = cnt >= AF_C;
  assign almost_empty = cnt <= AE_C;
  assign data_count   = cnt;
endmodule

// File: tb/tb_sfifo_ft_param.sv
// tb_sfifo_ft_param: queue-model scoreboard bench with directed and random traffic
module tb_sfifo_ft_param;
  localparam int W = 16;
  localparam int D = 32;
  localparam int AF = D - 2;
  localparam int AE = 2;
  localparam int CW = $clog2(D) + 1;
  logic clk = 0, rst_n = 0, flush = 0, wr_en = 0, rd_en = 0, err_clr = 0;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;
  logic full, empty, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0] data_count;
  int total = 0, bad = 0;
  logic [W-1:0] q[$];
  bit m_ovf = 0, m_unf = 0, fm, em, wa, ra;

  sfifo_ft_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .err_clr(err_clr), .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .data_count(data_count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic cyc(input logic w, input logic r, input logic [W-1:0] d, input logic f = 0, input logic c = 0);
    wr_en = w; rd_en = r; din = d; flush = f; err_clr = c;
    @(posedge clk);
    #1;
  endtask

  // reference: FIFO contents as a plain queue, updated on each edge from the request rules
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); m_ovf = 0; m_unf = 0;
    end else begin
      fm = q.size() == D;
      em = q.size() == 0;
      wa = !flush && wr_en && (!fm || rd_en);
      ra = !flush && rd_en && !em;
      m_ovf = (!flush && wr_en && fm && !rd_en) || (m_ovf && !err_clr);
      m_unf = (!flush && rd_en && em) || (m_unf && !err_clr);
      if (flush) q.delete();
      else begin
        if (ra) void'(q.pop_front());
        if (wa) q.push_back(din);
      end
    end
  end

  always @(negedge clk) begin
    chk("count", 32'(data_count), q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == D);
    chk("almost_full", almost_full, q.size() >= AF);
    chk("almost_empty", almost_empty, q.size() <= AE);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
    if (rst_n && rd_en && !flush && !empty && q.size() > 0) chk("dout", dout, q[0]);
  end

  task automatic chk_reset_vals(input string n);
    chk({n, "_empty"}, empty, 1);
    chk({n, "_full"}, full, 0);
    chk({n, "_ae"}, almost_empty, 1);
    chk({n, "_af"}, almost_full, 0);
    chk({n, "_count"}, 32'(data_count), 0);
    chk({n, "_ovf"}, overflow, 0);
    chk({n, "_unf"}, underflow, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1;
    for (int i = 1; i <= D; i++) begin
      cyc(1, 0, W'(i));
      if (i == 1) chk("first_wr_empty", empty, 0);
      chk("fill_af", almost_full, i >= AF);
    end
    chk("fill_full", full, 1);
    chk("fill_count", 32'(data_count), D);
    for (int i = 0; i < D; i++) begin
      chk("drain_dout", dout, W'(i + 1));
      chk("drain_ae", almost_empty, (D - i) <= AE);
      cyc(0, 1, '0);
    end
    chk("drain_empty", empty, 1);
    for (int i = 1; i <= D; i++) cyc(1, 0, W'(i + 100));
    cyc(1, 1, 16'hBEEF);
    chk("wr_rd_full_count", 32'(data_count), D);
    chk("wr_rd_full_ovf", overflow, 0);
    cyc(1, 0, 16'h1234);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", 32'(data_count), D);
    cyc(0, 0, '0, 0, 1);
    chk("ovf_clr", overflow, 0);
    for (int i = 0; i < D; i++) begin
      if (i == D - 1) chk("beef_last", dout, 16'hBEEF);
      cyc(0, 1, '0);
    end
    cyc(1, 1, 16'h0055);
    chk("wr_rd_empty_count", 32'(data_count), 1);
    chk("wr_rd_empty_unf", underflow, 1);
    cyc(0, 1, '0);
    cyc(0, 0, '0, 0, 1);
    for (int i = 0; i < 20; i++) cyc(1, 0, W'($urandom));
    for (int i = 0; i < 20; i++) cyc(0, 1, '0);
    for (int i = 0; i < 40; i++) cyc(1, 1'($urandom_range(0, 1)) && q.size() > 0, W'($urandom));
    cyc(1, 0, 16'hAAAA, 1);
    chk("flush_count", 32'(data_count), 0);
    chk("flush_empty", empty, 1);
    cyc(0, 0, '0);
    chk("flush_still_empty", empty, 1);
    cyc(0, 0, '0, 0, 1);
    for (int i = 0; i < D; i++) cyc(1, 0, W'($urandom));
    cyc(1, 0, '0);
    for (int i = 0; i < 15; i++) cyc(0, 1, '0);
    chk("pre_rst_count", 32'(data_count), 17);
    chk("pre_rst_ovf", overflow, 1);
    wr_en = 0; rd_en = 0;
    #2 rst_n = 0;
    #1 chk_reset_vals("async_rst");
    #1 rst_n = 1;
    @(posedge clk);
    #1;
    cyc(1, 0, 16'h7777);
    chk("post_rst_dout", dout, 16'h7777);
    chk("post_rst_count", 32'(data_count), 1);
    for (int i = 0; i < 3000; i++) begin
      int wp_ = (i / 250) % 2 ? 70 : 35;
      cyc($urandom_range(0, 99) < wp_, $urandom_range(0, 99) < 100 - wp_, W'($urandom),
          $urandom_range(0, 127) == 0, $urandom_range(0, 15) == 0);
    end
    for (int i = 0; i < D + 2; i++) cyc(0, 1, '0);
    cyc(0, 0, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
